rgmii_rxdec: RTL and testbench
==============================

RGMII_RXDEC -- requirements
Module: rgmii_rxdec

Interface
REQ-001 SHALL have parameter OPT_STRIP_PREAMBLE, default 1; 1 = preamble/SFD removed and checked, 0 = every DV byte passed through unchecked.
REQ-002 SHALL have parameter OPT_INBAND, default 1; 1 = in-band link status decoded, 0 = status outputs tied 0.
REQ-003 SHALL have i_clk  input  1  single receive clock; all logic on rising edge.
REQ-004 SHALL have i_reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have i_rxd  input  8  DDR samples of RXD[3:0]: bits [3:0] = first (rising-edge) sample of pins 3..0, bits [7:4] = second (falling-edge) sample.
REQ-006 SHALL have i_rxctl  input  2  DDR samples of RX_CTL: bit 0 = first sample, bit 1 = second sample.
REQ-007 SHALL have o_valid  output  1  one byte on o_data this cycle; no backpressure, consumer accepts every beat.
REQ-008 SHALL have o_data  output  8  received byte, first nibble in bits [3:0].
REQ-009 SHALL have o_last  output  1  final byte of frame, qualified by o_valid.
REQ-010 SHALL have o_err  output  1  frame contained RX_ER, qualified by o_valid & o_last.
REQ-011 SHALL have o_drop  output  1  single-cycle pulse: frame discarded for bad preamble.
REQ-012 SHALL have o_link_up, o_speed[1:0], o_full_duplex  outputs  1/2/1  latched in-band status.

Function
REQ-013 SHALL decode each cycle: dv = i_rxctl[0], er = i_rxctl[0] ^ i_rxctl[1], byte = i_rxd.
REQ-014 SHALL implement states DROP, IDLE, PREAMBLE, DATA.
REQ-015 DROP: stay while dv=1; dv=0 -> IDLE.
REQ-016 IDLE: dv=1 -> PREAMBLE if OPT_STRIP_PREAMBLE, else DATA with that byte captured as data.
REQ-017 PREAMBLE: dv=1 & byte=0x55 -> stay; dv=1 & byte=0xD5 -> DATA (SFD not emitted); dv=1 & other byte -> DROP with o_drop pulsed next cycle; dv=0 -> IDLE, no output, no o_drop.
REQ-018 DATA: dv=1 -> byte captured into a one-byte hold register; dv=0 -> IDLE.
REQ-019 A held byte SHALL be emitted on the cycle after the following input cycle, with o_last = !dv of that following cycle; byte sampled in cycle k appears at o_valid in cycle k+2.
REQ-020 Error flag SHALL set on any DATA-state cycle with dv=1 & er=1 (including the SFD cycle), be reported on the last beat via o_err, and clear on entry to IDLE.
REQ-021 Frame of zero data bytes (dv falls immediately after SFD) SHALL produce no output beat.
REQ-022 Back-to-back frames with a single dv=0 cycle between them SHALL both be received intact; last beat of frame 1 and first capture of frame 2 may coincide.
REQ-023 When OPT_INBAND=1 and i_rxctl=2'b00 in IDLE, status SHALL update next cycle: o_link_up=byte[0], o_speed=byte[2:1], o_full_duplex=byte[3].
REQ-024 dv=0 & er=1 (false carrier / carrier extension) SHALL cause no output and no status update.
REQ-025 o_valid, o_last, o_err, o_drop SHALL be registered outputs with no combinational path from inputs.

Reset
REQ-026 On i_reset assertion, immediately: state = DROP, hold register empty, error flag 0, all outputs 0.
REQ-027 Frame in progress at reset SHALL be abandoned with no o_last emitted; after release, no frame is accepted until dv has been seen low.

Structure
REQ-028 State encodings and constants PREAMBLE_BYTE=0x55, SFD_BYTE=0xD5 SHALL reside in the shared Ethernet package.
REQ-029 In-band status latch SHALL be a sub-module rgmii_inband; all else in rgmii_rxdec.
REQ-030 Block SHALL sit directly downstream of the five DDR input-register instances (4 RXD, 1 RX_CTL), with no additional input resynchronisation.

Verification
REQ-031 7x0x55, 0xD5, then data 0x01,0x02,0x03, then dv=0 -> three beats 0x01,0x02,0x03, o_last on 0x03 only, o_err=0, first beat 2 cycles after 0x01 input.
REQ-032 Same frame with er=1 on byte 0x02 -> same data, o_err=1 on last beat only.
REQ-033 0x55,0x55,0x3C,0x10 -> no o_valid, one o_drop pulse, next valid frame after dv=0 received normally.
REQ-034 i_rxctl=00, i_rxd=0x0D in IDLE -> o_link_up=1, o_speed=2'b10, o_full_duplex=1 next cycle; i_rxctl=10 leaves status unchanged.
REQ-035 Reset asserted mid-data, released while dv=1 -> outputs 0 immediately, remaining bytes ignored, next full frame received correctly.
REQ-036 Two frames separated by one dv=0 cycle -> both complete, each with exactly one o_last.

Source files
------------

// File: rtl/rgmii_rxdec_pkg.sv
// Shared Ethernet receive definitions: FSM encodings,
// preamble/SFD constants and the in-band status record.
package rgmii_rxdec_pkg;

  localparam logic [1:0] ST_DROP = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_PRE  = 2'd2;
  localparam logic [1:0] ST_DATA = 2'd3;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  typedef struct packed {
    logic       link_up;
    logic [1:0] speed;
    logic       full_duplex;
  } inband_t;

  function automatic inband_t inband_decode(
    input logic [3:0] nib
  );
    inband_t s;
    s.link_up     = nib[0];
    s.speed       = nib[2:1];
    s.full_duplex = nib[3];
    return s;
  endfunction

endpackage

// File: rtl/rgmii_rxdec_if.sv
// Byte stream plus drop/status outputs of the RGMII decoder.
// master = decoder side, slave = consumer side.
interface rgmii_rxdec_if;
  logic       o_valid;
  logic [7:0] o_data;
  logic       o_last;
  logic       o_err;
  logic       o_drop;
  logic       o_link_up;
  logic [1:0] o_speed;
  logic       o_full_duplex;

  modport master (
    output o_valid, o_data, o_last, o_err,
    output o_drop, o_link_up, o_speed,
    output o_full_duplex
  );

  modport slave (
    input o_valid, o_data, o_last, o_err,
    input o_drop, o_link_up, o_speed,
    input o_full_duplex
  );
endinterface

// File: rtl/rgmii_inband.sv
// In-band link status latch: captures the RXD nibble on
// enable. Ports: i_clk, i_reset, i_en, i_nib -> o_status.
module rgmii_inband
  import rgmii_rxdec_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_en,
  input  logic [3:0] i_nib,
  output inband_t    o_status
);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      o_status <= '0;
    else if (i_en)
      o_status <= inband_decode(i_nib);
  end

endmodule

// File: rtl/rgmii_rxdec.sv
// RGMII receive decoder: DDR samples in, framed bytes out.
// Ports: i_clk, i_reset, i_rxd, i_rxctl; rx = output bundle.
module rgmii_rxdec
  import rgmii_rxdec_pkg::*;
#(
  parameter bit OPT_STRIP_PREAMBLE = 1'b1,
  parameter bit OPT_INBAND         = 1'b1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic [7:0]    i_rxd,
  input  logic [1:0]    i_rxctl,
  rgmii_rxdec_if.master rx
);

  logic       dv;
  logic       er;
  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       cap;
  logic       err_set;
  logic       drop_nxt;
  logic       hold_vld;
  logic [7:0] hold;
  logic       err_flag;
  logic       ib_en;
  inband_t    ib;

  assign dv = i_rxctl[0];
  assign er = i_rxctl[0] ^ i_rxctl[1];

  always_comb begin
    state_nxt = state;
    cap       = 1'b0;
    err_set   = 1'b0;
    drop_nxt  = 1'b0;
    unique case (state)
      ST_DROP: begin
        if (!dv)
          state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (dv) begin
          if (OPT_STRIP_PREAMBLE) begin
            state_nxt = ST_PRE;
          end else begin
            state_nxt = ST_DATA;
            cap       = 1'b1;
            err_set   = er;
          end
        end
      end
      ST_PRE: begin
        if (!dv) begin
          state_nxt = ST_IDLE;
        end else if (i_rxd == SFD_BYTE) begin
          state_nxt = ST_DATA;
          err_set   = er;
        end else if (i_rxd != PREAMBLE_BYTE) begin
          state_nxt = ST_DROP;
          drop_nxt  = 1'b1;
        end
      end
      ST_DATA: begin
        if (dv) begin
          cap     = 1'b1;
          err_set = er;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_DROP;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= ST_DROP;
      hold_vld <= 1'b0;
      hold     <= '0;
      err_flag <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_vld <= cap;
      if (cap)
        hold <= i_rxd;
      if (state_nxt == ST_IDLE)
        err_flag <= 1'b0;
      else if (err_set)
        err_flag <= 1'b1;
    end
  end

  // The held byte learns it is last only when the next
  // cycle shows dv low, hence the one-byte delay.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rx.o_valid <= 1'b0;
      rx.o_data  <= '0;
      rx.o_last  <= 1'b0;
      rx.o_err   <= 1'b0;
      rx.o_drop  <= 1'b0;
    end else begin
      rx.o_valid <= hold_vld;
      if (hold_vld)
        rx.o_data <= hold;
      rx.o_last  <= hold_vld & ~dv;
      rx.o_err   <= hold_vld & ~dv & err_flag;
      rx.o_drop  <= drop_nxt;
    end
  end

  assign ib_en = OPT_INBAND
              && (state == ST_IDLE)
              && (i_rxctl == 2'b00);

  rgmii_inband u_inband (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_en     (ib_en),
    .i_nib    (i_rxd[3:0]),
    .o_status (ib)
  );

  assign rx.o_link_up     = ib.link_up;
  assign rx.o_speed       = ib.speed;
  assign rx.o_full_duplex = ib.full_duplex;

endmodule

// File: tb/tb_rgmii_rxdec.sv
// Scoreboard bench for rgmii_rxdec: directed frames,
// bad preamble, in-band status and mid-frame reset.
module tb_rgmii_rxdec;

  typedef struct {
    logic [7:0] d;
    bit         last;
    bit         err;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rxd = 8'h00;
  logic [1:0] rxctl = 2'b00;

  exp_t q[$];
  int   cyc_cnt = 0;
  int   applied = 0;
  int   miscompares = 0;
  int   drop_seen = 0;
  int   exp_drop = 0;

  rgmii_rxdec_if rx ();

  rgmii_rxdec #(
    .OPT_STRIP_PREAMBLE (1'b1),
    .OPT_INBAND         (1'b1)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .i_rxd   (rxd),
    .i_rxctl (rxctl),
    .rx      (rx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt++;

  always @(negedge clk) begin
    exp_t e;
    if (rx.o_drop)
      drop_seen++;
    if (rx.o_valid) begin
      applied++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL beat: unexpected data=%02h last=%0b",
                 rx.o_data, rx.o_last);
      end else begin
        e = q.pop_front();
        if (rx.o_data !== e.d || rx.o_last !== e.last ||
            rx.o_err !== e.err || cyc_cnt != e.cyc) begin
          miscompares++;
          $display("FAIL beat: got %02h l%0b e%0b @%0d, want %02h l%0b e%0b @%0d",
                   rx.o_data, rx.o_last, rx.o_err, cyc_cnt,
                   e.d, e.last, e.err, e.cyc);
        end
      end
    end
  end

  task automatic check(input string nm,
                       input int act, input int req);
    applied++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d", nm, act, req);
    end
  endtask

  task automatic drv(input logic [7:0] d,
                     input logic [1:0] c);
    rxd   = d;
    rxctl = c;
    @(posedge clk);
    #1;
  endtask

  // er_idx: -1 none, -2 on SFD, else index of data byte
  task automatic frame(input int n, input logic [7:0] b0,
                       input int er_idx);
    bit fe;
    fe = (er_idx != -1) && (er_idx < n);
    for (int i = 0; i < 7; i++) drv(8'h55, 2'b11);
    drv(8'hD5, (er_idx == -2) ? 2'b01 : 2'b11);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.d    = b0 + 8'(i);
      e.last = (i == n - 1);
      e.err  = fe && (i == n - 1);
      e.cyc  = cyc_cnt + 2;
      q.push_back(e);
      drv(e.d, (er_idx == i) ? 2'b01 : 2'b11);
    end
    drv(8'h00, 2'b00);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", rx.o_valid, 0);
    check("rst_last", rx.o_last, 0);
    check("rst_err", rx.o_err, 0);
    check("rst_drop", rx.o_drop, 0);
    check("rst_link", rx.o_link_up, 0);
    rst = 1'b0;
    drv(8'h00, 2'b00);

    frame(3, 8'h01, -1);
    frame(3, 8'h01, 1);
    frame(2, 8'hA0, -2);
    frame(0, 8'h00, -1);

    drv(8'h55, 2'b11);
    drv(8'h55, 2'b11);
    drv(8'h3C, 2'b11);
    exp_drop++;
    drv(8'h10, 2'b11);
    drv(8'h00, 2'b00);
    frame(2, 8'h70, -1);

    drv(8'h55, 2'b11);
    drv(8'h55, 2'b11);
    drv(8'h00, 2'b00);

    frame(3, 8'hC0, -1);
    frame(2, 8'hE0, 0);

    for (int i = 0; i < 7; i++) drv(8'h55, 2'b11);
    drv(8'hD5, 2'b11);
    drv(8'h11, 2'b11);
    drv(8'h22, 2'b11);
    check("pre_rst_valid", rx.o_valid, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", rx.o_valid, 0);
    check("mid_rst_data", rx.o_data, 0);
    drv(8'h33, 2'b11);
    drv(8'h33, 2'b11);
    rst = 1'b0;
    drv(8'h44, 2'b11);
    drv(8'h55, 2'b11);
    drv(8'hD5, 2'b11);
    drv(8'h66, 2'b11);
    drv(8'h00, 2'b00);
    frame(3, 8'h90, -1);

    drv(8'h0D, 2'b00);
    check("link_up", rx.o_link_up, 1);
    check("speed", rx.o_speed, 2);
    check("duplex", rx.o_full_duplex, 1);
    drv(8'h00, 2'b10);
    check("fc_link", rx.o_link_up, 1);
    check("fc_speed", rx.o_speed, 2);
    drv(8'hF2, 2'b00);
    check("st2_link", rx.o_link_up, 0);
    check("st2_speed", rx.o_speed, 1);
    check("st2_duplex", rx.o_full_duplex, 0);

    repeat (4) drv(8'h00, 2'b00);
    check("queue_left", q.size(), 0);
    check("drops", drop_seen, exp_drop);

    $display("== %0d vectors applied, %0d miscompares ==",
             applied, miscompares);
    $finish;
  end

endmodule
